multu_hilo_unit: RTL and testbench

- Multiplier datapath that responds to the 6-bit function code broadcast by the ALU control block.
- Runs a 32-step unsigned shift-add multiply when it receives MULTU (6'b011001).
- Commits the 64-bit product to the HiLo register pair when the control block issues the open-HiLo code (6'b111111).
- Serves MFHI/MFLO reads onto a 32-bit result bus that feeds the result mux.

---
 rtl/multu_hilo_unit.sv | 94 +++++++++
 tb/tb_multu_hilo_unit.sv | 130 +++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: 32-step unsigned shift-add multiplier that commits into HI/LO on command
// and serves MFHI/MFLO reads onto the result bus.
module multu_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] HILO  = 6'b111111;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [5:0]         prev_sig_q;
  logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [5:0]         count_q, count_d;
  logic               open_pend_q, open_pend_d, busy_q, busy_d, done_q, done_d;
  logic               start, is_hilo;
  logic [WIDTH:0]     sum;
  assign start   = (Signal == MULTU) && (prev_sig_q != MULTU);
  assign is_hilo = Signal == HILO;
  // Carry out of the upper-half add is kept so the shifted product never overflows.
  assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? mcand_q : '0};
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    count_d     = count_q;
    open_pend_d = open_pend_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        mcand_d     = dataA;
        prod_d      = {{WIDTH{1'b0}}, dataB};
        count_d     = '0;
        open_pend_d = 1'b0;
        state_d     = RUN;
      end
      RUN: if (Signal != MULTU && !is_hilo) state_d = IDLE;
      else begin
        prod_d      = {sum, prod_q[WIDTH-1:1]};
        count_d     = count_q + 6'd1;
        open_pend_d = open_pend_q | is_hilo;
        state_d     = (count_q == 6'(STEPS - 1)) ? DONE : RUN;
      end
      DONE: if (open_pend_q || is_hilo) begin
        {hi_d, lo_d} = prod_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      prev_sig_q  <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      count_q     <= '0;
      open_pend_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_sig_q  <= Signal;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      count_q     <= count_d;
      open_pend_q <= open_pend_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = (Signal == MFHI) ? hi_q : (Signal == MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed and randomized checks of multu_hilo_unit against a
// behavioural model that forms the product with a plain multiply.
module tb_multu_hilo_unit;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] HILO  = 6'b111111;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] ADD   = 6'b100000;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [5:0]  sig = '0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] dout;
  logic        busy, done;
  int tests = 0, fails = 0, dn_cnt = 0, d0 = 0;
  multu_hilo_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk(clk), .reset_n(reset_n), .Signal(sig), .dataA(a), .dataB(b),
    .dataOut(dout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  logic        m_run = 0, m_wait = 0, m_pend = 0, m_done = 0;
  int          m_k = 0;
  logic [5:0]  m_prev = '0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run <= 0; m_wait <= 0; m_pend <= 0; m_done <= 0; m_k <= 0;
      m_prev <= '0; m_prod <= '0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 0;
      m_prev <= sig;
      if (m_run) begin
        if (sig != MULTU && sig != HILO) m_run <= 0;
        else begin
          m_pend <= m_pend | (sig == HILO);
          m_k <= m_k + 1;
          if (m_k + 1 == 32) begin m_run <= 0; m_wait <= 1; end
        end
      end else if (m_wait) begin
        if (m_pend || sig == HILO) begin
          {m_hi, m_lo} <= m_prod; m_wait <= 0; m_done <= 1;
        end
      end else if (sig == MULTU && m_prev != MULTU) begin
        m_run <= 1; m_k <= 0; m_pend <= 0; m_prod <= 64'(a) * 64'(b);
      end
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("dataOut", 64'(dout), 64'((sig == MFHI) ? m_hi : (sig == MFLO) ? m_lo : 32'd0));
    chk("busy", 64'(busy), 64'(m_run | m_wait));
    chk("done", 64'(done), 64'(m_done));
    if (done) dn_cnt++;
  end
  task automatic cyc(input logic [5:0] s, input int n);
    repeat (n) begin sig = s; @(negedge clk); #1; end
  endtask
  task automatic rd(input string nm, input logic [31:0] eh, input logic [31:0] el);
    sig = MFHI; #1; chk({nm, "_hi"}, 64'(dout), 64'(eh));
    sig = MFLO; #1; chk({nm, "_lo"}, 64'(dout), 64'(el));
    @(negedge clk); #1;
  endtask
  task automatic mul(input logic [31:0] x, input logic [31:0] y);
    a = x; b = y;
    cyc(6'd0, 1); cyc(MULTU, 33); cyc(HILO, 1); cyc(6'd0, 2);
  endtask
  initial begin
    int n, ab;
    logic [5:0] s;
    sig = MFHI; #1;
    chk("rst_busy", 64'(busy), 0); chk("rst_done", 64'(done), 0); chk("rst_out", 64'(dout), 0);
    @(negedge clk); #1 reset_n = 1'b1;
    // Test 1: 3*5, HILO arrives while running, MULTU held afterwards must not restart.
    a = 3; b = 5; d0 = dn_cnt;
    cyc(6'd0, 1); cyc(MULTU, 31); cyc(HILO, 1); cyc(MULTU, 3);
    chk("t1_busy", 64'(busy), 0); chk("t1_done_cnt", 64'(dn_cnt - d0), 1);
    cyc(MULTU, 5); chk("t1_norestart", 64'(busy), 0);
    cyc(6'd0, 1); rd("t1", 32'd0, 32'd15);
    mul(32'hFFFFFFFF, 32'hFFFFFFFF); rd("t2", 32'hFFFFFFFE, 32'h00000001);
    mul(32'h12345678, 32'd0); rd("t3a", 32'd0, 32'd0);
    mul(32'h80000000, 32'd2); rd("t3b", 32'd1, 32'd0);
    // Test 4: abort at step 10.
    a = 32'd77; b = 32'd88; d0 = dn_cnt;
    cyc(6'd0, 1); cyc(MULTU, 10); cyc(ADD, 3);
    chk("t4_busy", 64'(busy), 0); chk("t4_nodone", 64'(dn_cnt - d0), 0);
    rd("t4", 32'd1, 32'd0);
    mul(32'd9, 32'd11); rd("t4r", 32'd0, 32'd99);
    // Test 5: wait in DONE without HILO.
    a = 32'd100000; b = 32'd300000; d0 = dn_cnt;
    cyc(6'd0, 1); cyc(MULTU, 50);
    chk("t5_busy", 64'(busy), 1);
    rd("t5_wait", 32'd0, 32'd99);
    chk("t5_still", 64'(busy), 1);
    cyc(HILO, 1); cyc(6'd0, 2);
    chk("t5_done_cnt", 64'(dn_cnt - d0), 1); chk("t5_busy2", 64'(busy), 0);
    rd("t5", 32'h00000006, 32'hFC23AC00);
    // Test 6: asynchronous reset mid-operation.
    a = 32'd1234; b = 32'd5678;
    cyc(6'd0, 1); cyc(MULTU, 20);
    sig = MFLO; #1;
    chk("t6_pre_busy", 64'(busy), 1); chk("t6_pre_lo", 64'(dout), 64'(32'hFC23AC00));
    reset_n = 1'b0; #1;
    chk("t6_busy", 64'(busy), 0); chk("t6_done", 64'(done), 0); chk("t6_out", 64'(dout), 0);
    @(negedge clk); #1 reset_n = 1'b1;
    rd("t6_clr", 32'd0, 32'd0);
    mul(32'd7, 32'd6); rd("t6", 32'd0, 32'd42);
    // Randomized operations with stray HILO codes and occasional aborts.
    for (int it = 0; it < 25; it++) begin
      a = $urandom; b = $urandom;
      n = $urandom_range(33, 40);
      ab = (it % 5 == 4) ? $urandom_range(1, 30) : 99;
      cyc(6'd0, 1);
      for (int i = 0; i < n; i++) begin
        s = ($urandom_range(0, 9) == 0) ? HILO : MULTU;
        cyc(i == ab ? ADD : s, 1);
      end
      cyc(HILO, 1); cyc(6'd0, 2);
      if (ab == 99) chk("rnd_prod", {m_hi, m_lo}, 64'(a) * 64'(b));
      rd("rnd", m_hi, m_lo);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
